md_sched: RTL and testbench

- Sequencing controller for the HI/LO multiply/divide resource of the P7 pipelined MIPS core; sits beside the E-stage ALU.
- Accepts mult/multu/div/divu/mthi/mtlo issued in E, models fixed multi-cycle latency with a busy counter, and owns the architectural HI/LO registers.
- Generates the D-stage stall for any HI/LO-using instruction while the unit is occupied.
- Honours the exception/interrupt cancel from M so a flushed instruction never modifies HI/LO.

---
 rtl/md_sched.sv | 167 ++++++++++++++++
 tb/tb_md_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// md_sched: HI/LO multiply/divide sequencer for the pipelined MIPS core.
// It computes the result in the accepting cycle and holds it in pending
// registers. HI/LO are updated only when the busy counter expires, so the
// resource looks like a fixed-latency multi-cycle unit to the pipeline.
module md_sched #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic        md_wr_hi,
    input  logic        md_wr_lo,
    input  logic        md_cancel,
    input  logic        md_use_d,
    output logic        md_busy,
    output logic        md_stall,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        hi_p_q, hi_p_d, lo_p_q, lo_p_d;
    logic               busy_q, busy_d;

    // Arithmetic datapath, evaluated on the live E-stage operands
    logic signed [31:0] aS, bS;
    logic signed [63:0] prodS;
    logic [63:0]        prodU;
    logic [31:0]        aMag, bMag, bMagSafe, bUSafe;
    logic [31:0]        qMag, rMag, quotS, remS, quotU, remU;
    logic [31:0]        resHi, resLo;
    logic               accept;

    assign aS    = md_a;
    assign bS    = md_b;
    assign prodS = 64'(aS) * 64'(bS);
    assign prodU = {32'd0, md_a} * {32'd0, md_b};

    // Signed divide is done on magnitudes so that the most-negative dividend
    // divided by -1 wraps to 0x80000000 instead of overflowing.
    assign aMag     = md_a[31] ? (32'd0 - md_a) : md_a;
    assign bMag     = md_b[31] ? (32'd0 - md_b) : md_b;
    assign bMagSafe = (bMag == 32'd0) ? 32'd1 : bMag;
    assign bUSafe   = (md_b == 32'd0) ? 32'd1 : md_b;
    assign qMag     = aMag / bMagSafe;
    assign rMag     = aMag % bMagSafe;
    assign quotS    = (md_a[31] ^ md_b[31]) ? (32'd0 - qMag) : qMag;
    assign remS     = md_a[31] ? (32'd0 - rMag) : rMag;
    assign quotU    = md_a / bUSafe;
    assign remU     = md_a % bUSafe;

    assign accept   = md_start & ~md_cancel & (state_q == IDLE);

    // Select the result for the requested operation; divide by zero gives
    // all-ones quotient and returns the dividend as remainder.
    always_comb begin
        resHi = 32'd0;
        resLo = 32'd0;
        case (md_op)
            2'b00: {resHi, resLo} = prodS;
            2'b01: {resHi, resLo} = prodU;
            2'b10: begin
                if (md_b == 32'd0) begin
                    resHi = md_a;
                    resLo = 32'hFFFF_FFFF;
                end else begin
                    resHi = remS;
                    resLo = quotS;
                end
            end
            default: begin
                if (md_b == 32'd0) begin
                    resHi = md_a;
                    resLo = 32'hFFFF_FFFF;
                end else begin
                    resHi = remU;
                    resLo = quotU;
                end
            end
        endcase
    end

    // Next-state logic: accept start or mthi/mtlo when idle, count down when busy
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_p_d  = hi_p_q;
        lo_p_d  = lo_p_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    hi_p_d = resHi;
                    lo_p_d = resLo;
                    if (md_op[1]) begin
                        cnt_d   = CNT_W'(DIV_CYCLES);
                        state_d = DIV;
                    end else begin
                        cnt_d   = CNT_W'(MUL_CYCLES);
                        state_d = MUL;
                    end
                end else if (!md_cancel) begin
                    if (md_wr_hi) begin
                        hi_d = md_a;
                    end
                    if (md_wr_lo) begin
                        lo_d = md_a;
                    end
                end
            end
            MUL, DIV: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = hi_p_q;
                    lo_d    = lo_p_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, counter, pending result and architectural HI/LO registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_p_q  <= 32'd0;
            lo_p_q  <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_p_q  <= hi_p_d;
            lo_p_q  <= lo_p_d;
            busy_q  <= busy_d;
        end
    end

    assign md_busy  = busy_q;
    assign md_stall = md_use_d & (busy_q | (md_start & ~md_cancel));
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: table-driven bench for md_sched with a HI/LO result scoreboard.
module tb_md_sched;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk;
    logic        reset_n;
    logic        md_start;
    logic [1:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_wr_hi;
    logic        md_wr_lo;
    logic        md_cancel;
    logic        md_use_d;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        logic        useD;
        int          disturb;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    vec_t        vecs[11];
    res_t        sb[$];
    int          total;
    int          bad;
    logic [31:0] curHi;
    logic [31:0] curLo;

    md_sched #(
        .MUL_CYCLES(MUL_N),
        .DIV_CYCLES(DIV_N),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .md_start(md_start),
        .md_op(md_op),
        .md_a(md_a),
        .md_b(md_b),
        .md_wr_hi(md_wr_hi),
        .md_wr_lo(md_wr_lo),
        .md_cancel(md_cancel),
        .md_use_d(md_use_d),
        .md_busy(md_busy),
        .md_stall(md_stall),
        .hi_out(hi_out),
        .lo_out(lo_out)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a stuck run still reports
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one operation from idle, check every busy cycle, then pop and compare
    task automatic applyStimulus(input vec_t v);
        int   n;
        int   w;
        res_t r;
        n = v.op[1] ? DIV_N : MUL_N;
        sb.push_back('{hi: v.expHi, lo: v.expLo});
        md_start  = 1'b1;
        md_op     = v.op;
        md_a      = v.a;
        md_b      = v.b;
        md_use_d  = v.useD;
        md_wr_hi  = (v.disturb == 4);
        md_wr_lo  = (v.disturb == 4);
        #1;
        checkOutput("stall_issue", {31'd0, md_stall}, {31'd0, v.useD});
        @(negedge clk);
        md_start = 1'b0;
        md_wr_hi = 1'b0;
        md_wr_lo = 1'b0;
        md_a     = $urandom;
        md_b     = $urandom;
        md_op    = 2'($urandom_range(0, 3));
        for (int i = 0; i < n; i++) begin
            md_start  = (v.disturb == 1) && (i == 2);
            md_cancel = (v.disturb == 2);
            md_wr_hi  = (v.disturb == 3);
            md_wr_lo  = (v.disturb == 3);
            if (v.disturb == 3) begin
                md_a = 32'hA5A5_A5A5;
            end
            #1;
            checkOutput("busy_high", {31'd0, md_busy}, 32'd1);
            checkOutput("stall_busy", {31'd0, md_stall}, {31'd0, v.useD});
            checkOutput("hi_hold", hi_out, curHi);
            checkOutput("lo_hold", lo_out, curLo);
            @(negedge clk);
        end
        md_start  = 1'b0;
        md_cancel = 1'b0;
        md_wr_hi  = 1'b0;
        md_wr_lo  = 1'b0;
        #1;
        checkOutput("busy_fall", {31'd0, md_busy}, 32'd0);
        w = 0;
        while (md_busy && w < 4) begin
            @(negedge clk);
            #1;
            w++;
        end
        checkOutput("stall_after", {31'd0, md_stall}, 32'd0);
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 32'd0, 32'd1);
        end else begin
            r = sb.pop_front();
            checkOutput("hi_result", hi_out, r.hi);
            checkOutput("lo_result", lo_out, r.lo);
            curHi = r.hi;
            curLo = r.lo;
        end
        md_use_d = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        curHi     = 32'd0;
        curLo     = 32'd0;
        reset_n   = 1'b0;
        md_start  = 1'b0;
        md_op     = 2'b00;
        md_a      = 32'd0;
        md_b      = 32'd0;
        md_wr_hi  = 1'b0;
        md_wr_lo  = 1'b0;
        md_cancel = 1'b0;
        md_use_d  = 1'b0;

        // op, a, b, expHi, expLo, useD, disturb (1 start, 2 cancel, 3 mthi/mtlo, 4 start+write)
        vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 0};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 0};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 2};
        vecs[3]  = '{2'b11, 32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF, 1'b0, 1};
        vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1, 3};
        vecs[5]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0};
        vecs[6]  = '{2'b11, 32'hFFFF_FFFF, 32'd16,       32'h0000_000F, 32'h0FFF_FFFF, 1'b1, 0};
        vecs[7]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 4};
        vecs[8]  = '{2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b1, 0};
        vecs[9]  = '{2'b10, 32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, 0};
        vecs[10] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 0};

        // Reset state
        #12;
        checkOutput("reset_busy", {31'd0, md_busy}, 32'd0);
        checkOutput("reset_hi", hi_out, 32'd0);
        checkOutput("reset_lo", lo_out, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
        end

        // Cancelled start: no busy, no stall, HI/LO unchanged
        md_start  = 1'b1;
        md_op     = 2'b00;
        md_a      = 32'd3;
        md_b      = 32'd3;
        md_cancel = 1'b1;
        md_use_d  = 1'b1;
        #1;
        checkOutput("cancel_stall", {31'd0, md_stall}, 32'd0);
        @(negedge clk);
        md_start = 1'b0;
        md_use_d = 1'b0;
        #1;
        checkOutput("cancel_busy", {31'd0, md_busy}, 32'd0);
        checkOutput("cancel_lo", lo_out, curLo);

        // Cancelled mthi
        md_wr_hi = 1'b1;
        md_a     = 32'hDEAD_BEEF;
        @(negedge clk);
        md_wr_hi  = 1'b0;
        md_cancel = 1'b0;
        #1;
        checkOutput("cancel_mthi", hi_out, curHi);

        // mtlo alone, then mthi and mtlo together
        md_wr_lo = 1'b1;
        md_a     = 32'h0000_1234;
        @(negedge clk);
        md_wr_lo = 1'b0;
        #1;
        checkOutput("mtlo_lo", lo_out, 32'h0000_1234);
        checkOutput("mtlo_hi", hi_out, curHi);
        md_wr_hi = 1'b1;
        md_wr_lo = 1'b1;
        md_a     = 32'h5555_AAAA;
        @(negedge clk);
        md_wr_hi = 1'b0;
        md_wr_lo = 1'b0;
        #1;
        checkOutput("both_hi", hi_out, 32'h5555_AAAA);
        checkOutput("both_lo", lo_out, 32'h5555_AAAA);
        curHi = 32'h5555_AAAA;
        curLo = 32'h5555_AAAA;
        @(negedge clk);

        // Asynchronous reset in the middle of a mult
        md_start = 1'b1;
        md_op    = 2'b00;
        md_a     = 32'd9;
        md_b     = 32'd9;
        @(negedge clk);
        md_start = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_busy", {31'd0, md_busy}, 32'd0);
        checkOutput("arst_hi", hi_out, 32'd0);
        checkOutput("arst_lo", lo_out, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        curHi   = 32'd0;
        curLo   = 32'd0;
        @(negedge clk);
        applyStimulus('{2'b00, 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A, 1'b1, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
